// File: rtl/fan_current_pkg.sv
// rtl/fan_current_pkg.sv - shared state type, ADC width and LTC2308 config-word layout
package fan_current_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_CONV, ST_SETUP, ST_SHIFT, ST_ACCUM} state_t;

  localparam int ADC_BITS = 12;
  localparam int CFG_BITS = 6;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  // Single-ended, unipolar, awake; channel bits scattered as the LTC2308 expects them
  function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] channel);
    logic [CFG_BITS-1:0] w;
    w          = '0;
    w[CFG_SD]  = 1'b1;
    w[CFG_OS]  = channel[0];
    w[CFG_S1]  = channel[2];
    w[CFG_S0]  = channel[1];
    w[CFG_UNI] = 1'b1;
    w[CFG_SLP] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/ltc2308_spi_xfer.sv
// rtl/ltc2308_spi_xfer.sv - one LTC2308 CONVST/SPI transaction: convert, shift config out and result in
module ltc2308_spi_xfer
  import fan_current_pkg::*;
#(
  parameter int SCK_DIV     = 2,
  parameter int CONV_CYCLES = 100,
  parameter int CHANNEL     = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_sdo,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_convst,
  output logic                o_sck,
  output logic                o_sdi,
  output logic [ADC_BITS-1:0] o_data
);

  localparam int CNT_MAX = (CONV_CYCLES > SCK_DIV) ? CONV_CYCLES : SCK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]    CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0]    HALF_LAST = CNT_W'(SCK_DIV - 1);
  localparam logic [3:0]          LAST_BIT  = 4'(ADC_BITS - 1);
  localparam logic [CFG_BITS-1:0] CFG       = cfg_word(3'(CHANNEL));

  state_t              r_state, w_state_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic                r_sck, w_sck_n;
  logic [3:0]          r_bit, w_bit_n;
  logic [CFG_BITS-1:0] r_cfg, w_cfg_n;
  logic [ADC_BITS-1:0] r_shift, w_shift_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sck   <= 1'b0;
      r_bit   <= '0;
      r_cfg   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_sck   <= w_sck_n;
      r_bit   <= w_bit_n;
      r_cfg   <= w_cfg_n;
      r_shift <= w_shift_n;
    end
  end

  // r_cfg doubles as the SDI shifter: it empties to zero after six falling edges
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_sck_n   = r_sck;
    w_bit_n   = r_bit;
    w_cfg_n   = r_cfg;
    w_shift_n = r_shift;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_n = ST_CONV;
          w_cnt_n   = '0;
        end
      end
      ST_CONV: begin
        if (r_cnt == CONV_LAST) begin
          w_state_n = ST_SETUP;
          w_cnt_n   = '0;
          w_cfg_n   = CFG;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      ST_SETUP: begin
        w_state_n = ST_SHIFT;
        w_cnt_n   = '0;
        w_bit_n   = '0;
        w_sck_n   = 1'b0;
      end
      ST_SHIFT: begin
        if (r_cnt != HALF_LAST) begin
          w_cnt_n = r_cnt + 1'b1;
        end else begin
          w_cnt_n = '0;
          w_sck_n = ~r_sck;
          if (!r_sck) begin
            w_shift_n = {r_shift[ADC_BITS-2:0], i_sdo};
          end else begin
            w_cfg_n = {r_cfg[CFG_BITS-2:0], 1'b0};
            if (r_bit == LAST_BIT) w_state_n = ST_ACCUM;
            else                   w_bit_n   = r_bit + 1'b1;
          end
        end
      end
      ST_ACCUM: w_state_n = ST_IDLE;
      default:  w_state_n = ST_IDLE;
    endcase
  end

  assign o_busy   = (r_state != ST_IDLE);
  assign o_done   = (r_state == ST_ACCUM);
  assign o_convst = (r_state == ST_CONV);
  assign o_sck    = r_sck;
  assign o_sdi    = r_cfg[CFG_BITS-1];
  assign o_data   = r_shift;

endmodule

// File: rtl/fan_current_sampler.sv
// rtl/fan_current_sampler.sv - periodic LTC2308 sampling with a boxcar moving average of fan current
module fan_current_sampler
  import fan_current_pkg::*;
#(
  parameter int SCK_DIV       = 2,
  parameter int CONV_CYCLES   = 100,
  parameter int SAMPLE_PERIOD = 5000,
  parameter int AVG_LOG2      = 4,
  parameter int CHANNEL       = 0
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  output logic                o_adc_convst,
  output logic                o_adc_sck,
  output logic                o_adc_sdi,
  input  logic                i_adc_sdo,
  output logic [31:0]         o_current_average,
  output logic [ADC_BITS-1:0] o_sample_raw,
  output logic                o_sample_valid,
  output logic                o_overrun
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = ADC_BITS + AVG_LOG2;
  localparam int TICK_W = $clog2(SAMPLE_PERIOD);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);

  logic [TICK_W-1:0]   r_tick_cnt;
  logic                r_enable_d;
  logic                r_discard;
  logic [ADC_BITS-1:0] r_ring [DEPTH];
  logic [AVG_LOG2-1:0] r_wr_ptr;
  logic [SUM_W-1:0]    r_sum;
  logic [31:0]         r_avg;
  logic [ADC_BITS-1:0] r_raw;
  logic                r_valid;
  logic                r_overrun;

  logic                w_tick, w_start, w_busy, w_done, w_accept, w_en_rise;
  logic [ADC_BITS-1:0] w_data;
  logic [SUM_W-1:0]    w_sum_next;

  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_start    = w_tick && i_enable && !w_busy;
  assign w_en_rise  = i_enable && !r_enable_d;
  assign w_accept   = w_done && !r_discard;
  // sum always holds at least the oldest entry, so the subtraction cannot wrap
  assign w_sum_next = r_sum + SUM_W'(w_data) - SUM_W'(r_ring[r_wr_ptr]);

  ltc2308_spi_xfer #(
    .SCK_DIV     (SCK_DIV),
    .CONV_CYCLES (CONV_CYCLES),
    .CHANNEL     (CHANNEL)
  ) u_xfer (
    .i_clk    (i_clock),
    .i_rst    (i_reset),
    .i_start  (w_start),
    .i_sdo    (i_adc_sdo),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_convst (o_adc_convst),
    .o_sck    (o_adc_sck),
    .o_sdi    (o_adc_sdi),
    .o_data   (w_data)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tick_cnt <= '0;
      r_enable_d <= 1'b0;
      r_discard  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) r_ring[i] <= '0;
      r_wr_ptr   <= '0;
      r_sum      <= '0;
      r_avg      <= '0;
      r_raw      <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_enable_d <= i_enable;
      // the ADC returns the previous transaction's channel, so the first result after a restart is stale
      if (w_en_rise)   r_discard <= 1'b1;
      else if (w_done) r_discard <= 1'b0;
      r_overrun  <= w_tick && w_busy;
      r_valid    <= w_accept;
      if (w_accept) begin
        r_ring[r_wr_ptr] <= w_data;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
        r_sum            <= w_sum_next;
        r_avg            <= {{(32-ADC_BITS){1'b0}}, w_sum_next[SUM_W-1:AVG_LOG2]};
        r_raw            <= w_data;
      end
    end
  end

  assign o_current_average = r_avg;
  assign o_sample_raw      = r_raw;
  assign o_sample_valid    = r_valid;
  assign o_overrun         = r_overrun;

endmodule

// File: tb/tb_fan_current_sampler.sv
// tb/tb_fan_current_sampler.sv - self-checking bench for fan_current_sampler with an LTC2308 model
module tb_fan_current_sampler;

  localparam int SP   = 300;
  localparam int SP_O = 120;
  localparam int CH   = 5;
  localparam int CONV = 100;
  localparam int SDIV = 2;
  localparam int WIN  = 16;
  localparam int LAT  = CONV + 1 + 24*SDIV + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  always #5 clk = ~clk;

  logic        m_convst, m_sck, m_sdi, m_valid, m_ovr;
  logic [31:0] m_avg;
  logic [11:0] m_raw;
  logic        o_convst, o_sck, o_sdi, o_valid, o_ovr;
  logic [31:0] o_avg;
  logic [11:0] o_raw;
  logic        adc_sdo = 1'b0;

  fan_current_sampler #(.SCK_DIV(SDIV), .CONV_CYCLES(CONV), .SAMPLE_PERIOD(SP),
                        .AVG_LOG2(4), .CHANNEL(CH)) u_main (
    .i_clock(clk), .i_reset(rst), .i_enable(en),
    .o_adc_convst(m_convst), .o_adc_sck(m_sck), .o_adc_sdi(m_sdi), .i_adc_sdo(adc_sdo),
    .o_current_average(m_avg), .o_sample_raw(m_raw), .o_sample_valid(m_valid), .o_overrun(m_ovr)
  );

  fan_current_sampler #(.SCK_DIV(SDIV), .CONV_CYCLES(CONV), .SAMPLE_PERIOD(SP_O),
                        .AVG_LOG2(4), .CHANNEL(0)) u_ovr (
    .i_clock(clk), .i_reset(rst), .i_enable(en),
    .o_adc_convst(o_convst), .o_adc_sck(o_sck), .o_adc_sdi(o_sdi), .i_adc_sdo(1'b1),
    .o_current_average(o_avg), .o_sample_raw(o_raw), .o_sample_valid(o_valid), .o_overrun(o_ovr)
  );

  int n_asrt = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc = rst ? 0 : cyc + 1;

  // LTC2308 model: one scripted result per CONVST pulse, records SCK/SDI/CONVST behaviour
  logic [11:0] script [0:255];
  int          tidx = -1;
  int          conv_hi = 0, rises = 0, bit_i = 0;
  logic [11:0] sdi_bits = '0, word = '0;
  logic        sck_bad = 1'b0, p_convst = 1'b0, p_sck = 1'b0;

  always @(negedge clk) begin
    if (m_convst && !p_convst) begin
      tidx++;
      conv_hi  = 0;
      rises    = 0;
      sdi_bits = '0;
      sck_bad  = 1'b0;
      word     = script[tidx];
      bit_i    = 0;
      adc_sdo  = word[11];
    end
    if (m_convst) conv_hi++;
    if (m_convst && m_sck) sck_bad = 1'b1;
    if (m_sck && !p_sck) begin
      rises++;
      sdi_bits = {sdi_bits[10:0], m_sdi};
    end
    if (!m_sck && p_sck) begin
      bit_i++;
      adc_sdo = (bit_i < 12) ? word[11-bit_i] : 1'b0;
    end
    p_convst = m_convst;
    p_sck    = m_sck;
  end

  int hist[$];
  int exp_tidx = 1;
  int exp_cfg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int model_avg();
    int s = 0;
    for (int i = 0; i < WIN && i < hist.size(); i++) s += hist[hist.size()-1-i];
    return s / WIN;
  endfunction

  task automatic wait_valid();
    int n = 0;
    step();
    while (!m_valid && n < 2*SP + 200) begin
      step();
      n++;
    end
    chk("valid_timeout", m_valid, 1);
  endtask

  task automatic wait_sck_high();
    int n = 0;
    step();
    while (!m_sck && n < 2*SP) begin
      step();
      n++;
    end
    chk("sck_timeout", m_sck, 1);
  endtask

  task automatic check_sample();
    int exp_raw;
    exp_raw = int'(script[tidx]);
    hist.push_back(exp_raw);
    chk("txn_index", tidx, exp_tidx);
    exp_tidx = tidx + 1;
    chk("sample_raw", m_raw, exp_raw);
    chk("current_average", m_avg, model_avg());
    chk("latency_phase", cyc % SP, (SP - 1 + LAT) % SP);
    chk("sck_rises", rises, 12);
    chk("sdi_cfg", sdi_bits, exp_cfg << 6);
    chk("convst_high", conv_hi, CONV);
    chk("sck_during_convst", sck_bad, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_avg"}, m_avg, 0);
    chk({tag, "_raw"}, m_raw, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_ovr"}, m_ovr, 0);
    chk({tag, "_convst"}, m_convst, 0);
    chk({tag, "_sck"}, m_sck, 0);
    chk({tag, "_sdi"}, m_sdi, 0);
  endtask

  initial begin
    int last, seen_valid, seen_sck, pend, busy_end, v_at, first, o_cnt;
    exp_cfg = 32 | ((CH & 1) << 4) | (((CH >> 2) & 1) << 3) | (((CH >> 1) & 1) << 2) | 2;
    for (int i = 0; i < 256; i++) begin
      if (i <= 20)      script[i] = 12'd100;
      else if (i <= 36) script[i] = 12'd4095;
      else              script[i] = 12'($urandom_range(0, 4095));
    end

    #23;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 1; k <= 20; k++) begin
      wait_valid();
      check_sample();
      if (k == 16) chk("avg_window_full", m_avg, 100);
      step();
      chk("valid_width", m_valid, 0);
    end

    for (int k = 1; k <= 16; k++) begin
      wait_valid();
      check_sample();
      if (k == 15) chk("avg_step_not_yet", m_avg, (15*4095 + 100) / 16);
      if (k == 16) chk("avg_step_reached", m_avg, 4095);
    end

    for (int k = 0; k < 8; k++) begin
      wait_valid();
      check_sample();
    end

    wait_sck_high();
    en = 1'b0;
    wait_valid();
    check_sample();
    last = tidx;
    seen_valid = 0;
    seen_sck = 0;
    repeat (2*SP) begin
      step();
      seen_valid += int'(m_valid);
      seen_sck   += int'(m_sck);
    end
    chk("idle_no_txn", tidx, last);
    chk("idle_no_valid", seen_valid, 0);
    chk("idle_sck_low", seen_sck, 0);
    chk("idle_avg_held", m_avg, model_avg());

    en = 1'b1;
    exp_tidx = tidx + 2;
    wait_valid();
    check_sample();
    wait_valid();
    check_sample();

    wait_sck_high();
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    hist.delete();
    exp_tidx = tidx + 2;
    @(posedge clk);
    #1 rst = 1'b0;

    pend = 0;
    busy_end = -1;
    v_at = -1;
    first = 1;
    o_cnt = 0;
    for (int n = 0; n < 1300; n++) begin
      step();
      chk("overrun_pulse", o_ovr, pend);
      pend = 0;
      chk("ovr_inst_valid", o_valid, (cyc == v_at));
      if (o_valid) begin
        o_cnt++;
        chk("ovr_inst_raw", o_raw, 4095);
      end
      if (m_valid) check_sample();
      if (cyc % SP_O == SP_O - 1) begin
        if (cyc <= busy_end) pend = 1;
        else begin
          busy_end = cyc + LAT - 1;
          v_at = first ? -1 : cyc + LAT;
          first = 0;
        end
      end
    end
    chk("ovr_inst_avg", o_avg, (o_cnt < WIN ? o_cnt : WIN) * 4095 / WIN);
    chk("ovr_inst_count", o_cnt, 4);
    chk("main_after_reset", hist.size(), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
